data_mem_responder: RTL and testbench
=====================================

// Module: data_mem_responder
// PURPOSE
//  Target (responder) end of the processor data-memory port: accepts one load/store
//  request at a time over a valid/ready handshake and returns a one-cycle response pulse.
//  64-bit doubleword storage, byte addressed, with a programmable wait-state count.
//  Replaces the zero-latency DataMemory so the core and future caches see a realistic latency.
// PARAMETERS
//  DEPTH_WORDS  32  number of 64-bit words (power of 2, >=2)
//  WAIT_CYCLES  2   wait states between acceptance and response (0..15)
//  DATA_W       64  data width; fixed at 64 (LDUR/STUR doubleword)
// PORTS
//  clk        in   1   single clock, rising edge
//  reset      in   1   asynchronous, active-high reset
//  req_valid  in   1   request present
//  req_ready  out  1   responder can accept; high only in IDLE
//  req_write  in   1   1 = store (STUR), 0 = load (LDUR)
//  req_addr   in   64  byte address (output_alu of core)
//  req_wdata  in   64  store data (reg_data_2 of core)
//  rsp_valid  out  1   one-cycle response pulse
//  rsp_rdata  out  64  load data; 0 for stores and errors
//  rsp_error  out  1   misaligned or out-of-range access, valid with rsp_valid
// BEHAVIOUR
//  - Reset (async assert, sync release): state=IDLE, req_ready=1, rsp_valid=0,
//    rsp_rdata=0, rsp_error=0, wait counter=0, all memory words cleared to 0.
//  - FSM: IDLE -> WAIT on accept (req_valid&&req_ready); IDLE -> RESP if WAIT_CYCLES==0;
//    WAIT -> RESP when counter reaches WAIT_CYCLES-1; RESP -> IDLE unconditionally.
//  - On accept, req_write/req_addr/req_wdata are registered; inputs may change after.
//  - Latency: rsp_valid asserted exactly WAIT_CYCLES+1 cycles after the accept edge.
//    Minimum spacing between accepts: WAIT_CYCLES+2 cycles.
//  - rsp_valid high for exactly one cycle (RESP); rsp_rdata/rsp_error registered and held
//    until the next response (not cleared after the pulse).
//  - Word index = addr[3 +: log2(DEPTH_WORDS)].
//  - Error: addr[2:0]!=0, or addr >= DEPTH_WORDS*8 (full 64-bit compare, no wrap).
//    Error -> rsp_error=1, rsp_rdata=0, no memory write.
//  - Store commits on the clock edge entering RESP; load reads the array on the same edge,
//    so a load sees every store whose response has already completed.
//  - Store response: rsp_rdata=0, rsp_error=0 unless erroneous.
//  - req_valid while not IDLE: ignored (req_ready=0); request must be held by initiator.
//  - Reset mid-transaction: transaction dropped, no write committed, no response issued.
//  - Counter width 4 bits; never wraps (bounded by WAIT_CYCLES<=15).
// STRUCTURE
//  - Package mem_pkg: state enum {IDLE, WAIT, RESP}, DATA_W, WORD_BYTES=8, log2 helper.
//  - Sub-module mem_array: DEPTH_WORDS x 64 storage, one write port, one read port,
//    reset clear; responder holds FSM, counter, request registers, address check.
// TESTING
//  1 Reset: reset=1 mid-cycle -> req_ready=1, rsp_valid=0, rsp_rdata=0 immediately.
//  2 Store 64'hDEAD_BEEF_0123_4567 to addr 0x10, then load 0x10 -> rsp_rdata matches,
//    rsp_error=0; rsp_valid exactly 3 cycles after each accept (WAIT_CYCLES=2).
//  3 Load addr 0x0C (misaligned) and 0x100 (out of range, DEPTH 32) -> rsp_error=1,
//    rsp_rdata=0; follow-up load of 0x100-0x100+0 region unchanged (no corruption).
//  4 Hold req_valid high continuously with changing addr -> accepts only in IDLE,
//    spacing 4 cycles, each response tied to the address present at its accept edge.
//  5 Assert reset during WAIT of store to 0x08 -> no rsp_valid; later load 0x08 returns 0.
//  6 WAIT_CYCLES=0 build: store 0x18=5 then load 0x18 -> rsp_valid 1 cycle after accept, data 5.

Source files
------------

// File: rtl/data_mem_responder_pkg.sv
// Shared definitions for the data-memory responder.
// Contents: data width, bytes per word, responder FSM state type and a
// compile-time log2 helper used to size word indices.
package data_mem_responder_pkg;

  localparam int unsigned DATA_W     = 64;
  localparam int unsigned WORD_BYTES = 8;

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StResp
  } state_e;

  // Smallest r with 2**r >= n (n >= 1).
  function automatic int unsigned log2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(n)) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/data_mem_responder_mem_array.sv
// Doubleword storage for the data-memory responder.
// Ports:
//   clk      in   clock, rising edge
//   reset    in   asynchronous active-high reset, clears every word
//   wr_en    in   write strobe
//   wr_idx   in   word index written when wr_en is high
//   wr_data  in   word written
//   rd_idx   in   word index read
//   rd_data  out  combinational read of rd_idx
module data_mem_responder_mem_array
  import data_mem_responder_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 32,
  parameter int unsigned IDX_W       = log2(DEPTH_WORDS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem_q [DEPTH_WORDS];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(DEPTH_WORDS); i++) mem_q[i] <= '0;
    end else if (wr_en) begin
      mem_q[wr_idx] <= wr_data;
    end
  end

  assign rd_data = mem_q[rd_idx];

endmodule

// File: rtl/data_mem_responder.sv
// Responder end of the processor data-memory port.
// Accepts one load/store at a time over req_valid/req_ready, waits WAIT_CYCLES
// cycles, then pulses rsp_valid for one cycle with load data and error flag.
// Ports:
//   clk        in   clock, rising edge
//   reset      in   asynchronous active-high reset
//   req_valid  in   request present
//   req_ready  out  high only while idle
//   req_write  in   1 = store, 0 = load
//   req_addr   in   64-bit byte address
//   req_wdata  in   store data
//   rsp_valid  out  one-cycle response pulse
//   rsp_rdata  out  load data; 0 for stores and errors; held between responses
//   rsp_error  out  misaligned or out-of-range access; held between responses
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 32,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [DATA_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_error
);

  localparam int unsigned IDX_W = log2(DEPTH_WORDS);
  localparam int unsigned OFS_W = log2(WORD_BYTES);
  localparam logic [DATA_W-1:0] ADDR_LIMIT = DATA_W'(DEPTH_WORDS) * DATA_W'(WORD_BYTES);
  localparam logic [3:0] CNT_LAST = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  state_e            state_q, state_d;
  logic [3:0]        cnt_q;
  logic              write_q;
  logic [DATA_W-1:0] addr_q, wdata_q;
  logic [DATA_W-1:0] rdata_q;
  logic              error_q;

  logic              accept, enter_resp;
  logic              cur_write, cur_error;
  logic [DATA_W-1:0] cur_addr, cur_wdata;
  logic [IDX_W-1:0]  cur_idx;
  logic [DATA_W-1:0] mem_rdata;

  assign accept = req_valid && (state_q == StIdle);

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= StIdle;
    else       state_q <= state_d;
  end

  // Next state.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (accept) state_d = (WAIT_CYCLES == 0) ? StResp : StWait;
      StWait: if (cnt_q == CNT_LAST) state_d = StResp;
      StResp: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM outputs.
  always_comb begin
    req_ready = (state_q == StIdle);
    rsp_valid = (state_q == StResp);
  end

  assign enter_resp = (state_d == StResp) && (state_q != StResp);

  // With zero wait states the response edge is the accept edge, so the live
  // request must be used; otherwise the captured copy is.
  always_comb begin
    if (state_q == StIdle) begin
      cur_write = req_write;
      cur_addr  = req_addr;
      cur_wdata = req_wdata;
    end else begin
      cur_write = write_q;
      cur_addr  = addr_q;
      cur_wdata = wdata_q;
    end
  end

  // Full-width range compare so high addresses never alias into the array.
  assign cur_error = (cur_addr[OFS_W-1:0] != '0) || (cur_addr >= ADDR_LIMIT);
  assign cur_idx   = cur_addr[OFS_W +: IDX_W];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q   <= '0;
      write_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      error_q <= 1'b0;
    end else begin
      if (accept) begin
        cnt_q   <= '0;
        write_q <= req_write;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
      end else if (state_q == StWait) begin
        cnt_q <= cnt_q + 4'd1;
      end
      if (enter_resp) begin
        rdata_q <= (cur_write || cur_error) ? '0 : mem_rdata;
        error_q <= cur_error;
      end
    end
  end

  assign rsp_rdata = rdata_q;
  assign rsp_error = error_q;

  data_mem_responder_mem_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .IDX_W       (IDX_W)
  ) u_mem_array (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (enter_resp && cur_write && !cur_error),
    .wr_idx  (cur_idx),
    .wr_data (cur_wdata),
    .rd_idx  (cur_idx),
    .rd_data (mem_rdata)
  );

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: a 2-wait-state instance driven by directed and
// random transactions against a word-array model, plus a zero-wait instance.
module tb_data_mem_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_write, rsp_valid, rsp_error;
  logic [63:0] req_addr, req_wdata, rsp_rdata;
  logic        req_valid0, req_ready0, req_write0, rsp_valid0, rsp_error0;
  logic [63:0] req_addr0, req_wdata0, rsp_rdata0;

  int checks   = 0;
  int failures = 0;

  logic [63:0] model_mem [32];

  always #5 clk = ~clk;

  data_mem_responder #(.DEPTH_WORDS(32), .WAIT_CYCLES(2)) u_dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_error(rsp_error)
  );

  data_mem_responder #(.DEPTH_WORDS(32), .WAIT_CYCLES(0)) u_dut0 (
    .clk(clk), .reset(reset), .req_valid(req_valid0), .req_ready(req_ready0),
    .req_write(req_write0), .req_addr(req_addr0), .req_wdata(req_wdata0),
    .rsp_valid(rsp_valid0), .rsp_rdata(rsp_rdata0), .rsp_error(rsp_error0)
  );

  function automatic void model_clear();
    for (int i = 0; i < 32; i++) model_mem[i] = 64'd0;
  endfunction

  // Memory of 32 doublewords = 256 bytes; anything not a multiple of 8 or past
  // the end is an error and has no effect.
  function automatic void model_access(input logic w, input logic [63:0] a, input logic [63:0] d,
                                       output logic [63:0] exp_rd, output logic exp_er);
    exp_er = (a % 8 != 0) || (a >= 64'd256);
    exp_rd = 64'd0;
    if (!exp_er) begin
      if (w) model_mem[a / 8] = d;
      else   exp_rd = model_mem[a / 8];
    end
  endfunction

  // Issue one request on the 2-wait instance; lat counts cycles from the
  // accept cycle to the cycle where rsp_valid is seen.
  task automatic do_txn(input logic w, input logic [63:0] a, input logic [63:0] d,
                        output logic [63:0] rd, output logic er, output int lat);
    int guard;
    @(negedge clk);
    guard = 0;
    while (!req_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    req_valid = 1'b1;
    req_write = w;
    req_addr  = a;
    req_wdata = d;
    @(negedge clk);
    req_valid = 1'b0;
    req_write = 1'($urandom);
    req_addr  = {$urandom, $urandom};
    req_wdata = {$urandom, $urandom};
    lat = 1;
    while (!rsp_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    rd = rsp_rdata;
    er = rsp_error;
  endtask

  task automatic test_reset();
    logic [63:0] rd;
    logic er;
    int lat;
    do_txn(1'b1, 64'h20, 64'hA5A5_0000_FFFF_1234, rd, er, lat);
    do_txn(1'b0, 64'h20, 64'h0, rd, er, lat);
    checks++;
    if (rd !== 64'hA5A5_0000_FFFF_1234) begin
      failures++;
      $display("FAIL reset_preload rdata got=%h exp=%h", rd, 64'hA5A5_0000_FFFF_1234);
    end
    // Accept a load, then hit reset half way through a WAIT cycle.
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_addr = 64'h20;
    @(negedge clk);
    req_valid = 1'b0;
    #2 reset = 1'b1;
    model_clear();
    #1;
    checks++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_rdata !== 64'd0 || rsp_error !== 1'b0) begin
      failures++;
      $display("FAIL reset_async ready=%b valid=%b rdata=%h err=%b exp ready=1 valid=0 rdata=0 err=0",
               req_ready, rsp_valid, rsp_rdata, rsp_error);
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    do_txn(1'b0, 64'h20, 64'h0, rd, er, lat);
    checks++;
    if (rd !== 64'd0 || er !== 1'b0) begin
      failures++;
      $display("FAIL reset_mem_cleared rdata=%h err=%b exp rdata=0 err=0", rd, er);
    end
  endtask

  task automatic test_store_load();
    logic [63:0] rd, exp_rd;
    logic er, exp_er;
    int lat;
    model_access(1'b1, 64'h10, 64'hDEAD_BEEF_0123_4567, exp_rd, exp_er);
    do_txn(1'b1, 64'h10, 64'hDEAD_BEEF_0123_4567, rd, er, lat);
    checks++;
    if (lat != 3 || rd !== exp_rd || er !== exp_er) begin
      failures++;
      $display("FAIL store_0x10 lat=%0d rdata=%h err=%b exp lat=3 rdata=%h err=%b",
               lat, rd, er, exp_rd, exp_er);
    end
    model_access(1'b0, 64'h10, 64'h0, exp_rd, exp_er);
    do_txn(1'b0, 64'h10, 64'h0, rd, er, lat);
    checks++;
    if (lat != 3 || rd !== exp_rd || er !== exp_er) begin
      failures++;
      $display("FAIL load_0x10 lat=%0d rdata=%h err=%b exp lat=3 rdata=%h err=%b",
               lat, rd, er, exp_rd, exp_er);
    end
    // One cycle after the pulse: pulse gone, data held.
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b0 || rsp_rdata !== exp_rd) begin
      failures++;
      $display("FAIL rsp_hold valid=%b rdata=%h exp valid=0 rdata=%h", rsp_valid, rsp_rdata, exp_rd);
    end
  endtask

  task automatic test_errors();
    logic [63:0] addrs [5];
    logic        wr [5];
    logic [63:0] rd, exp_rd;
    logic er, exp_er;
    int lat;
    addrs[0] = 64'h0C;  wr[0] = 1'b0;
    addrs[1] = 64'h100; wr[1] = 1'b0;
    addrs[2] = 64'h110; wr[2] = 1'b1;
    addrs[3] = 64'h8000_0000_0000_0010; wr[3] = 1'b1;
    addrs[4] = 64'h10;  wr[4] = 1'b0;
    for (int i = 0; i < 5; i++) begin
      model_access(wr[i], addrs[i], 64'hFFFF_EEEE_DDDD_CCCC, exp_rd, exp_er);
      do_txn(wr[i], addrs[i], 64'hFFFF_EEEE_DDDD_CCCC, rd, er, lat);
      checks++;
      if (lat != 3 || rd !== exp_rd || er !== exp_er) begin
        failures++;
        $display("FAIL error_case%0d addr=%h lat=%0d rdata=%h err=%b exp lat=3 rdata=%h err=%b",
                 i, addrs[i], lat, rd, er, exp_rd, exp_er);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] q_rd [$];
    logic        q_er [$];
    int          q_cyc [$];
    logic [63:0] exp_rd, got_rd;
    logic        exp_er, got_er;
    int          last_acc, ecyc;
    last_acc = -1;
    req_valid = 1'b1;
    for (int cyc = 0; cyc < 52; cyc++) begin
      @(negedge clk);
      if (rsp_valid) begin
        got_rd = rsp_rdata;
        got_er = rsp_error;
        checks++;
        if (q_rd.size() == 0) begin
          failures++;
          $display("FAIL b2b_unexpected_rsp cycle=%0d", cyc);
        end else begin
          exp_rd = q_rd.pop_front();
          exp_er = q_er.pop_front();
          ecyc   = q_cyc.pop_front();
          if (got_rd !== exp_rd || got_er !== exp_er || cyc - ecyc != 3) begin
            failures++;
            $display("FAIL b2b_rsp cycle=%0d lat=%0d rdata=%h err=%b exp lat=3 rdata=%h err=%b",
                     cyc, cyc - ecyc, got_rd, got_er, exp_rd, exp_er);
          end
        end
      end
      if (cyc < 44) begin
        req_write = 1'($urandom);
        req_addr  = {56'd0, 5'($urandom_range(0, 31)), 3'b000};
        req_wdata = {$urandom, $urandom};
        if (req_ready) begin
          if (last_acc >= 0) begin
            checks++;
            if (cyc - last_acc != 4) begin
              failures++;
              $display("FAIL b2b_spacing got=%0d exp=4", cyc - last_acc);
            end
          end
          last_acc = cyc;
          model_access(req_write, req_addr, req_wdata, exp_rd, exp_er);
          q_rd.push_back(exp_rd);
          q_er.push_back(exp_er);
          q_cyc.push_back(cyc);
        end
      end else begin
        req_valid = 1'b0;
      end
    end
    checks++;
    if (q_rd.size() != 0 || last_acc < 0) begin
      failures++;
      $display("FAIL b2b_drain pending=%0d last_accept=%0d exp pending=0", q_rd.size(), last_acc);
    end
  endtask

  task automatic test_reset_mid();
    logic [63:0] rd;
    logic er;
    int seen;
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 64'h08; req_wdata = 64'h1234_5678_9ABC_DEF0;
    @(negedge clk);
    req_valid = 1'b0;
    reset = 1'b1;
    model_clear();
    seen = 0;
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (rsp_valid) seen++;
    end
    checks++;
    if (seen != 0) begin
      failures++;
      $display("FAIL reset_mid_no_rsp pulses=%0d exp=0", seen);
    end
    do_txn(1'b0, 64'h08, 64'h0, rd, er, seen);
    checks++;
    if (rd !== 64'd0 || er !== 1'b0 || seen != 3) begin
      failures++;
      $display("FAIL reset_mid_load lat=%0d rdata=%h err=%b exp lat=3 rdata=0 err=0", seen, rd, er);
    end
  endtask

  task automatic test_random();
    logic [63:0] a, d, rd, exp_rd;
    logic w, er, exp_er;
    int lat, sel;
    for (int i = 0; i < 40; i++) begin
      sel = int'($urandom_range(0, 9));
      if (sel <= 6)      a = {56'd0, 5'($urandom_range(0, 31)), 3'b000};
      else if (sel == 7) a = {56'd0, 5'($urandom), 3'($urandom_range(1, 7))};
      else if (sel == 8) a = 64'($urandom_range(32, 127)) * 64'd8;
      else               a = {1'b1, 60'($urandom), 3'b000};
      w = (i < 8) ? 1'b1 : 1'($urandom);
      d = {$urandom, $urandom};
      model_access(w, a, d, exp_rd, exp_er);
      do_txn(w, a, d, rd, er, lat);
      checks++;
      if (lat != 3 || rd !== exp_rd || er !== exp_er) begin
        failures++;
        $display("FAIL random%0d w=%b addr=%h lat=%0d rdata=%h err=%b exp lat=3 rdata=%h err=%b",
                 i, w, a, lat, rd, er, exp_rd, exp_er);
      end
    end
  endtask

  task automatic test_zero_wait();
    logic        ws [3];
    logic [63:0] as [3];
    logic [63:0] er_rd [3];
    logic        er_er [3];
    int lat;
    ws[0] = 1'b1; as[0] = 64'h18; er_rd[0] = 64'd0; er_er[0] = 1'b0;
    ws[1] = 1'b0; as[1] = 64'h18; er_rd[1] = 64'd5; er_er[1] = 1'b0;
    ws[2] = 1'b0; as[2] = 64'h1B; er_rd[2] = 64'd0; er_er[2] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (req_ready0 !== 1'b1) begin
        failures++;
        $display("FAIL zw_ready%0d got=%b exp=1", i, req_ready0);
      end
      req_valid0 = 1'b1; req_write0 = ws[i]; req_addr0 = as[i]; req_wdata0 = 64'd5;
      @(negedge clk);
      req_valid0 = 1'b0; req_addr0 = {$urandom, $urandom}; req_wdata0 = {$urandom, $urandom};
      lat = 1;
      while (!rsp_valid0 && lat < 10) begin
        @(negedge clk);
        lat++;
      end
      checks++;
      if (lat != 1 || rsp_rdata0 !== er_rd[i] || rsp_error0 !== er_er[i]) begin
        failures++;
        $display("FAIL zw_txn%0d lat=%0d rdata=%h err=%b exp lat=1 rdata=%h err=%b",
                 i, lat, rsp_rdata0, rsp_error0, er_rd[i], er_er[i]);
      end
      @(negedge clk);
      checks++;
      if (rsp_valid0 !== 1'b0 || req_ready0 !== 1'b1) begin
        failures++;
        $display("FAIL zw_pulse%0d valid=%b ready=%b exp valid=0 ready=1", i, rsp_valid0, req_ready0);
      end
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
    req_valid0 = 1'b0; req_write0 = 1'b0; req_addr0 = '0; req_wdata0 = '0;
    model_clear();
    repeat (2) @(negedge clk);
    checks++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_rdata !== 64'd0 || rsp_error !== 1'b0) begin
      failures++;
      $display("FAIL initial_reset ready=%b valid=%b rdata=%h err=%b exp ready=1 valid=0 rdata=0 err=0",
               req_ready, rsp_valid, rsp_rdata, rsp_error);
    end
    reset = 1'b0;
    test_reset();
    test_store_load();
    test_errors();
    test_back_to_back();
    test_reset_mid();
    test_random();
    test_zero_wait();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
